// File: rtl/axi_ad9250_pngen.sv
// AD9250 test-pattern source: PN9/PN23 Fibonacci LFSRs, ramp, constant and
// passthrough, one registered output stage, plus single-word bit-0 error injection.
module axi_ad9250_pngen #(
  parameter logic [8:0]  SEED_PN9  = 9'h1ff,
  parameter logic [22:0] SEED_PN23 = 23'h7fffff
) (
  input  logic        adc_clk,
  input  logic        adc_rst,
  input  logic        adc_enable,
  input  logic [3:0]  adc_pnseq_sel,
  input  logic [13:0] adc_pat_data,
  input  logic [27:0] adc_src_data,
  input  logic        adc_src_valid,
  input  logic        adc_err_inject,
  output logic [27:0] adc_data,
  output logic        adc_valid,
  output logic        adc_or,
  output logic        adc_err_pending
);

  typedef enum logic [3:0] {
    SRC_PN9   = 4'd0,
    SRC_PN23  = 4'd1,
    SRC_RAMP  = 4'd2,
    SRC_CONST = 4'd3,
    SRC_PASS  = 4'd4
  } src_e;

  logic [8:0]  pn9_q, pn9_d, pn9_cur, h9;
  logic [22:0] pn23_q, pn23_d, pn23_cur, h23;
  logic [13:0] cnt_q, cnt_d, cnt_cur;
  logic [3:0]  sel_q, sel_d;
  logic [27:0] data_q, data_d, word9, word23;
  logic        valid_q, valid_d;
  logic        or_q, or_d;
  logic        err_q, err_d;
  logic        sel_chg, nb9, nb23;

  // Next-state: restart on select change, generate 28 PN bits, mux source, apply injection
  always_comb begin
    sel_chg  = (adc_pnseq_sel != sel_q);
    sel_d    = adc_pnseq_sel;
    // Any select change restarts every generator; only the selected one is observable.
    pn9_cur  = sel_chg ? SEED_PN9  : pn9_q;
    pn23_cur = sel_chg ? SEED_PN23 : pn23_q;
    cnt_cur  = sel_chg ? '0 : cnt_q;

    // History bit 0 is the most recent sequence bit; first generated bit ends up in [27].
    h9     = pn9_cur;
    h23    = pn23_cur;
    word9  = '0;
    word23 = '0;
    nb9    = 1'b0;
    nb23   = 1'b0;
    for (int unsigned i = 0; i < 28; i++) begin
      nb9    = h9[4] ^ h9[8];
      nb23   = h23[17] ^ h23[22];
      word9  = {word9[26:0], nb9};
      word23 = {word23[26:0], nb23};
      h9     = {h9[7:0], nb9};
      h23    = {h23[21:0], nb23};
    end

    pn9_d   = pn9_cur;
    pn23_d  = pn23_cur;
    cnt_d   = cnt_cur;
    data_d  = '0;
    valid_d = 1'b0;
    or_d    = 1'b0;
    if (adc_enable) begin
      valid_d = 1'b1;
      case (adc_pnseq_sel)
        SRC_PN9: begin
          data_d = word9;
          pn9_d  = h9;
        end
        SRC_PN23: begin
          data_d = word23;
          pn23_d = h23;
        end
        SRC_RAMP: begin
          data_d = {cnt_cur + 14'd1, cnt_cur};
          cnt_d  = cnt_cur + 14'd2;
        end
        SRC_CONST: data_d = {adc_pat_data, adc_pat_data};
        SRC_PASS: begin
          data_d  = adc_src_data;
          valid_d = adc_src_valid;
          or_d    = (adc_src_data[13:0] == '1) || (adc_src_data[13:0] == '0) ||
                    (adc_src_data[27:14] == '1) || (adc_src_data[27:14] == '0);
        end
        default: data_d = '0;
      endcase
    end

    // Corruption touches only the output word, never generator state.
    err_d = err_q;
    if (err_q && valid_d) begin
      data_d[0] = ~data_d[0];
      err_d     = 1'b0;
    end else if (adc_err_inject) begin
      err_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      pn9_q   <= SEED_PN9;
      pn23_q  <= SEED_PN23;
      cnt_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      or_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pn9_q   <= pn9_d;
      pn23_q  <= pn23_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      or_q    <= or_d;
      err_q   <= err_d;
    end
  end

  assign adc_data        = data_q;
  assign adc_valid       = valid_q;
  assign adc_or          = or_q;
  assign adc_err_pending = err_q;

endmodule

// File: tb/tb_axi_ad9250_pngen.sv
// Directed scoreboard bench for axi_ad9250_pngen.
module tb_axi_ad9250_pngen;

  localparam logic [8:0]  SEED9  = 9'h1ff;
  localparam logic [22:0] SEED23 = 23'h7fffff;
  localparam int          NWORDS = 420;
  localparam int          N9     = 9 + 28 * NWORDS;
  localparam int          N23    = 23 + 28 * NWORDS;

  logic        clk = 1'b0;
  logic        rst, en, src_valid, inj;
  logic [3:0]  sel;
  logic [13:0] pat;
  logic [27:0] src;
  logic [27:0] adc_data;
  logic        adc_valid, adc_or, adc_err_pending;

  always #5 clk = ~clk;

  axi_ad9250_pngen #(
    .SEED_PN9  (SEED9),
    .SEED_PN23 (SEED23)
  ) dut (
    .adc_clk         (clk),
    .adc_rst         (rst),
    .adc_enable      (en),
    .adc_pnseq_sel   (sel),
    .adc_pat_data    (pat),
    .adc_src_data    (src),
    .adc_src_valid   (src_valid),
    .adc_err_inject  (inj),
    .adc_data        (adc_data),
    .adc_valid       (adc_valid),
    .adc_or          (adc_or),
    .adc_err_pending (adc_err_pending)
  );

  typedef struct {
    logic [27:0] d;
    logic        v;
    logic        o;
    logic        p;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference sequences as flat bit arrays: index 0..(L-1) holds the seed history.
  bit   b9  [0:N9-1];
  bit   b23 [0:N23-1];

  // Reference model state
  logic [3:0]  m_sel;
  int          m_w9, m_w23;
  logic [13:0] m_cnt;
  bit          m_pend;

  function automatic logic [27:0] pn_word(input bit is23, input int w);
    logic [27:0] r;
    r = '0;
    for (int j = 0; j < 28; j++)
      r = {r[26:0], (is23 ? b23[23 + 28 * w + j] : b9[9 + 28 * w + j])};
    return r;
  endfunction

  task automatic step(input string tag);
    exp_t e, g;
    e.d = '0; e.v = 1'b0; e.o = 1'b0;
    if (rst) begin
      m_sel = '0; m_w9 = 0; m_w23 = 0; m_cnt = '0; m_pend = 1'b0;
    end else begin
      if (sel != m_sel) begin
        m_w9 = 0; m_w23 = 0; m_cnt = '0; m_sel = sel;
      end
      if (en) begin
        e.v = 1'b1;
        if (sel == 4'd0) begin
          e.d = pn_word(1'b0, m_w9); m_w9++;
        end else if (sel == 4'd1) begin
          e.d = pn_word(1'b1, m_w23); m_w23++;
        end else if (sel == 4'd2) begin
          e.d[13:0]  = m_cnt;
          e.d[27:14] = m_cnt + 14'd1;
          m_cnt      = m_cnt + 14'd2;
        end else if (sel == 4'd3) begin
          e.d = {pat, pat};
        end else if (sel == 4'd4) begin
          e.d = src;
          e.v = src_valid;
          e.o = (src[13:0] == 14'h3fff) || (src[13:0] == 14'h0000) ||
                (src[27:14] == 14'h3fff) || (src[27:14] == 14'h0000);
        end
      end
      if (m_pend && e.v) begin
        e.d[0] = ~e.d[0];
        m_pend = 1'b0;
      end else if (inj) begin
        m_pend = 1'b1;
      end
    end
    e.p = m_pend;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    n_vec++;
    assert (adc_data === g.d) else begin
      n_err++; $error("FAIL %s adc_data got %h want %h", tag, adc_data, g.d);
    end
    n_vec++;
    assert (adc_valid === g.v) else begin
      n_err++; $error("FAIL %s adc_valid got %b want %b", tag, adc_valid, g.v);
    end
    n_vec++;
    assert (adc_or === g.o) else begin
      n_err++; $error("FAIL %s adc_or got %b want %b", tag, adc_or, g.o);
    end
    n_vec++;
    assert (adc_err_pending === g.p) else begin
      n_err++; $error("FAIL %s adc_err_pending got %b want %b", tag, adc_err_pending, g.p);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 9; i++)  b9[8 - i]   = SEED9[i];
    for (int k = 9; k < N9; k++) b9[k]       = b9[k - 5] ^ b9[k - 9];
    for (int i = 0; i < 23; i++) b23[22 - i] = SEED23[i];
    for (int k = 23; k < N23; k++) b23[k]    = b23[k - 18] ^ b23[k - 23];
    m_sel = '0; m_w9 = 0; m_w23 = 0; m_cnt = '0; m_pend = 1'b0;

    // Reset dominates enable, injection and select change
    rst = 1'b1; en = 1'b1; sel = 4'd0; pat = '0; src = '0; src_valid = 1'b0; inj = 1'b1;
    step("reset");
    sel = 4'd3;
    step("reset_selchg");
    rst = 1'b0; inj = 1'b0; sel = 4'd0;

    // PN9 from seed
    step("pn9_first");
    n_vec++;
    assert (adc_data[27:19] === 9'b000001111) else begin
      n_err++; $error("FAIL pn9_head got %b want %b", adc_data[27:19], 9'b000001111);
    end
    for (int i = 0; i < 199; i++) step("pn9");

    // Enable gap holds the sequence
    en = 1'b0;
    for (int i = 0; i < 50; i++) step("pn9_gap");
    en = 1'b1;
    for (int i = 0; i < 60; i++) step("pn9_resume");

    // PN23 restart and single-word injection at word 100
    sel = 4'd1;
    for (int i = 0; i < 100; i++) step("pn23");
    inj = 1'b1;
    step("pn23_inj");
    inj = 1'b0;
    for (int i = 0; i < 50; i++) step("pn23_after_inj");

    // Pending injection survives disable; repeated pulses ignored
    inj = 1'b1;
    step("inj_arm");
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("inj_hold");
    en = 1'b1; inj = 1'b0;
    for (int i = 0; i < 5; i++) step("inj_apply");

    // Ramp across the wrap
    sel = 4'd2;
    for (int i = 0; i < 8194; i++) step("ramp");

    // Constant pattern
    sel = 4'd3; pat = 14'h1234;
    step("const_a");
    step("const_a2");
    pat = 14'h3fff;
    step("const_b");

    // Passthrough
    sel = 4'd4; src = {14'h3fff, 14'h0123}; src_valid = 1'b1;
    step("pass_or");
    src = {14'h0100, 14'h0123};
    step("pass_noor");
    src = {14'h0000, 14'h0100}; src_valid = 1'b0;
    step("pass_invalid");

    // Unsupported select
    sel = 4'd9;
    step("sel_unsup");
    step("sel_unsup2");

    // Reset mid-PN9 restarts from seed
    sel = 4'd0;
    for (int i = 0; i < 20; i++) step("pn9_pre_rst");
    rst = 1'b1;
    step("pn9_rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step("pn9_post_rst");

    // Reset with concurrent inject and select change, PN23 after release
    rst = 1'b1; inj = 1'b1; sel = 4'd1;
    step("rst_inj_sel");
    step("rst_inj_sel2");
    rst = 1'b0; inj = 1'b0;
    for (int i = 0; i < 30; i++) step("pn23_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
